// File: rtl/fetch_aligner.sv
// Fetch aligner: turns word-aligned fetch words into whole RISC-V instructions.
// Compressed/halfword support is built only when ALIGNER_RVC_EN is defined.
module fetch_aligner #(
  parameter int unsigned XLEN      = 32,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            word_valid_i,
  output logic            word_ready_o,
  input  logic [31:0]     word_data_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] flush_pc_i,
  output logic            instr_valid_o,
  input  logic            instr_ready_i,
  output logic [31:0]     instr_o,
  output logic [XLEN-1:0] instr_pc_o,
  output logic            instr_is_comp_o
);

  logic [2:0][15:0] hbuf_q, hbuf_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic             drop_lo_q, drop_lo_d;

  logic             is_long;
  logic             iss_valid;
  logic             issue;
  logic             accept;
  logic [1:0]       cons;
  logic [1:0]       cnt_post;
  logic [1:0]       add;
  logic [2:0][15:0] sh;

`ifdef ALIGNER_RVC_EN
  assign is_long   = hbuf_q[0][1:0] == 2'b11;
  assign iss_valid = is_long ? (cnt_q >= 2'd2)
                             : (cnt_q != 2'd0);
`else
  assign is_long   = 1'b1;
  assign iss_valid = cnt_q >= 2'd2;
`endif

  assign word_ready_o    = cnt_q <= 2'd1;
  assign accept          = word_valid_i
                         & word_ready_o
                         & ~flush_i;
  assign issue           = iss_valid & instr_ready_i;
  assign instr_valid_o   = iss_valid;
  assign instr_pc_o      = pc_q;
  assign instr_is_comp_o = iss_valid & ~is_long;

  assign instr_o = !iss_valid ? NOP_INSTR
                 : is_long    ? {hbuf_q[1], hbuf_q[0]}
                 :              {16'h0000, hbuf_q[0]};

  assign cons     = !issue  ? 2'd0
                  : is_long ? 2'd2
                  :           2'd1;
  assign cnt_post = cnt_q - cons;

  // Consume from the head, shift down, then append behind what is left.
  always_comb begin
    sh  = '0;
    add = 2'd0;
    unique case (1'b1)
      (cons == 2'd2): sh[0]   = hbuf_q[2];
      (cons == 2'd1): sh[1:0] = hbuf_q[2:1];
      default:        sh      = hbuf_q;
    endcase
    if (accept) begin
      if (drop_lo_q) begin
        add = 2'd1;
        if (cnt_post[0]) sh[1] = word_data_i[31:16];
        else             sh[0] = word_data_i[31:16];
      end else begin
        add = 2'd2;
        if (cnt_post[0]) begin
          sh[1] = word_data_i[15:0];
          sh[2] = word_data_i[31:16];
        end else begin
          sh[0] = word_data_i[15:0];
          sh[1] = word_data_i[31:16];
        end
      end
    end
  end

  always_comb begin
    hbuf_d    = sh;
    cnt_d     = cnt_post + add;
    drop_lo_d = accept ? 1'b0 : drop_lo_q;
    pc_d      = pc_q;
    if (issue)
      pc_d = pc_q + (is_long ? XLEN'(4) : XLEN'(2));
    if (flush_i) begin
      hbuf_d = hbuf_q;
      cnt_d  = 2'd0;
      pc_d   = flush_pc_i;
`ifdef ALIGNER_RVC_EN
      drop_lo_d = flush_pc_i[1];
`else
      drop_lo_d = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hbuf_q    <= '0;
      cnt_q     <= 2'd0;
      pc_q      <= '0;
      drop_lo_q <= 1'b0;
    end else begin
      hbuf_q    <= hbuf_d;
      cnt_q     <= cnt_d;
      pc_q      <= pc_d;
      drop_lo_q <= drop_lo_d;
    end
  end

endmodule

// File: tb/tb_fetch_aligner.sv
// Directed table-driven bench for fetch_aligner.
// Extra compressed-instruction vectors are enabled by ALIGNER_RVC_EN.
`timescale 1ns/1ps
module tb_fetch_aligner;

  localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef ALIGNER_RVC_EN
  localparam logic RVC = 1'b1;
`else
  localparam logic RVC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        word_valid_i = 1'b0;
  logic        word_ready_o;
  logic [31:0] word_data_i = '0;
  logic        flush_i = 1'b0;
  logic [31:0] flush_pc_i = '0;
  logic        instr_valid_o;
  logic        instr_ready_i = 1'b0;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        instr_is_comp_o;

  always #5 clk = ~clk;

  fetch_aligner #(
    .XLEN      (32),
    .NOP_INSTR (NOP)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .word_valid_i    (word_valid_i),
    .word_ready_o    (word_ready_o),
    .word_data_i     (word_data_i),
    .flush_i         (flush_i),
    .flush_pc_i      (flush_pc_i),
    .instr_valid_o   (instr_valid_o),
    .instr_ready_i   (instr_ready_i),
    .instr_o         (instr_o),
    .instr_pc_o      (instr_pc_o),
    .instr_is_comp_o (instr_is_comp_o)
  );

  typedef struct {
    logic        fl;
    logic [31:0] fpc;
    logic        wv;
    logic [31:0] wd;
    logic        rdy;
    logic        ev;
    logic [31:0] ei;
    logic [31:0] epc;
    logic        ec;
    logic        ewr;
  } vec_t;

  vec_t tbl[$];
  int checks = 0;
  int errors = 0;

  function automatic vec_t mk(
    input logic fl, input logic [31:0] fpc,
    input logic wv, input logic [31:0] wd,
    input logic rdy, input logic ev,
    input logic [31:0] ei, input logic [31:0] epc,
    input logic ec, input logic ewr);
    vec_t v;
    v.fl = fl; v.fpc = fpc; v.wv = wv; v.wd = wd;
    v.rdy = rdy; v.ev = ev; v.ei = ei; v.epc = epc;
    v.ec = ec; v.ewr = ewr;
    return v;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic expect_o(input string nm, input logic v,
                          input logic [31:0] i,
                          input logic [31:0] pc,
                          input logic c, input logic wr);
    chk({nm, ".valid"}, {31'd0, instr_valid_o}, {31'd0, v});
    chk({nm, ".instr"}, instr_o, i);
    chk({nm, ".pc"}, instr_pc_o, pc);
    chk({nm, ".comp"}, {31'd0, instr_is_comp_o}, {31'd0, c});
    chk({nm, ".wready"}, {31'd0, word_ready_o}, {31'd0, wr});
  endtask

  // Inputs change at the falling edge; outputs are sampled 1ns later.
  task automatic drive(input logic fl, input logic [31:0] fpc,
                       input logic wv, input logic [31:0] wd,
                       input logic rdy);
    @(negedge clk);
    flush_i       = fl;
    flush_pc_i    = fpc;
    word_valid_i  = wv;
    word_data_i   = wd;
    instr_ready_i = rdy;
    #1;
  endtask

  initial begin
    // 32-bit stream, stalls, flush priority, PC wrap
    tbl.push_back(mk(1, 32'h100, 0, 0, 0, 0, NOP, 32'h0, 0, 1));
    tbl.push_back(mk(0, 0, 1, 32'h00A00093, 1, 0, NOP, 32'h100, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 32'h00A00093, 32'h100, 0, 0));
    tbl.push_back(mk(0, 0, 1, 32'h00B00113, 0, 0, NOP, 32'h104, 0, 1));
    tbl.push_back(mk(0, 0, 1, 32'hDEADBEEF, 0, 1, 32'h00B00113, 32'h104, 0, 0));
    tbl.push_back(mk(0, 0, 1, 32'hDEADBEEF, 0, 1, 32'h00B00113, 32'h104, 0, 0));
    tbl.push_back(mk(0, 0, 1, 32'h12345678, 1, 1, 32'h00B00113, 32'h104, 0, 0));
    tbl.push_back(mk(0, 0, 1, 32'h002081B3, 1, 0, NOP, 32'h108, 0, 1));
    tbl.push_back(mk(0, 0, 1, 32'h40000093, 1, 1, 32'h002081B3, 32'h108, 0, 0));
    tbl.push_back(mk(1, 32'h500, 1, 32'h00000513, 1, 0, NOP, 32'h10C, 0, 1));
    tbl.push_back(mk(0, 0, 1, 32'h00100593, 1, 0, NOP, 32'h500, 0, 1));
    tbl.push_back(mk(1, 32'h600, 0, 0, 1, 1, 32'h00100593, 32'h500, 0, 0));
    tbl.push_back(mk(1, 32'h602, 0, 0, 1, 0, NOP, 32'h600, 0, 1));
    tbl.push_back(mk(0, 0, 1, 32'h0001FFFF, 1, 0, NOP, 32'h602, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1,
                     RVC ? 32'h00000001 : 32'h0001FFFF,
                     32'h602, RVC, RVC));
    tbl.push_back(mk(1, 32'hFFFFFFFC, 0, 0, 1, 0, NOP,
                     RVC ? 32'h604 : 32'h606, 0, 1));
    tbl.push_back(mk(0, 0, 1, 32'h00A00093, 1, 0, NOP, 32'hFFFFFFFC, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 32'h00A00093, 32'hFFFFFFFC, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, NOP, 32'h0, 0, 1));
`ifdef ALIGNER_RVC_EN
    // two c.li in one word, then a 32-bit op straddling two words
    tbl.push_back(mk(1, 32'h200, 0, 0, 1, 0, NOP, 32'h0, 0, 1));
    tbl.push_back(mk(0, 0, 1, 32'h45054501, 1, 0, NOP, 32'h200, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 32'h00004501, 32'h200, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 32'h00004505, 32'h202, 1, 1));
    tbl.push_back(mk(1, 32'h300, 0, 0, 1, 0, NOP, 32'h204, 0, 1));
    tbl.push_back(mk(0, 0, 1, 32'h00934501, 1, 0, NOP, 32'h300, 0, 1));
    tbl.push_back(mk(0, 0, 1, 32'h458500A0, 1, 1, 32'h00004501, 32'h300, 1, 0));
    tbl.push_back(mk(0, 0, 1, 32'h458500A0, 1, 0, NOP, 32'h302, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 32'h00A00093, 32'h302, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 32'h00004585, 32'h306, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, NOP, 32'h308, 0, 1));
`endif

    #2;
    expect_o("reset", 0, NOP, 32'h0, 0, 1);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[k]) begin
      drive(tbl[k].fl, tbl[k].fpc, tbl[k].wv, tbl[k].wd, tbl[k].rdy);
      expect_o($sformatf("row%0d", k), tbl[k].ev, tbl[k].ei,
               tbl[k].epc, tbl[k].ec, tbl[k].ewr);
    end

`ifdef ALIGNER_RVC_EN
    // full three-halfword buffer held off by the consumer
    drive(1, 32'h402, 0, 0, 1);
    drive(0, 0, 1, 32'h4501FFFF, 0);
    expect_o("c3.load", 0, NOP, 32'h402, 0, 1);
    drive(0, 0, 1, 32'h00A00093, 0);
    expect_o("c3.one", 1, 32'h00004501, 32'h402, 1, 1);
    for (int n = 0; n < 5; n++) begin
      drive(0, 0, 1, 32'hFFFFFFFF, 0);
      expect_o($sformatf("c3.hold%0d", n), 1, 32'h00004501, 32'h402, 1, 0);
    end
    drive(0, 0, 0, 0, 1);
    expect_o("c3.rel", 1, 32'h00004501, 32'h402, 1, 0);
    drive(0, 0, 0, 0, 1);
    expect_o("c3.next", 1, 32'h00A00093, 32'h404, 0, 0);
    drive(0, 0, 0, 0, 1);
    expect_o("c3.empty", 0, NOP, 32'h408, 0, 1);
`endif

    // consumer stall with a word waiting upstream
    drive(1, 32'h800, 0, 0, 1);
    drive(0, 0, 1, 32'h00C00193, 0);
    expect_o("st.load", 0, NOP, 32'h800, 0, 1);
    for (int n = 0; n < 5; n++) begin
      drive(0, 0, 1, 32'h00D00213, 0);
      expect_o($sformatf("st.hold%0d", n), 1, 32'h00C00193, 32'h800, 0, 0);
    end
    drive(0, 0, 1, 32'h00D00213, 1);
    expect_o("st.rel", 1, 32'h00C00193, 32'h800, 0, 0);
    drive(0, 0, 1, 32'h00D00213, 1);
    expect_o("st.acc", 0, NOP, 32'h804, 0, 1);
    drive(0, 0, 0, 0, 0);
    expect_o("st.next", 1, 32'h00D00213, 32'h804, 0, 0);

    // asynchronous reset in the middle of a cycle
    #2;
    rst_n = 1'b0;
    #1;
    expect_o("async_rst", 0, NOP, 32'h0, 0, 1);
    @(negedge clk);
    expect_o("rst_hold", 0, NOP, 32'h0, 0, 1);
    rst_n = 1'b1;
    drive(0, 0, 1, 32'h00E00293, 1);
    drive(0, 0, 0, 0, 1);
    expect_o("post_rst", 1, 32'h00E00293, 32'h0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
